mem_probe_responder: RTL

MEM_PROBE_RESPONDER -- requirements
Module: mem_probe_responder

---
 rtl/mipstest_pkg.sv | 17 +
 rtl/probe_timeout_ctr.sv | 40 ++++
 rtl/mem_probe_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mipstest_pkg.sv
// Shared definitions for the memory probe responder.
//   probe_state_e   : responder FSM state encoding
//   PROBE_SEL_DATA  : probe_sel value selecting the data memory
//   PROBE_SEL_INST  : probe_sel value selecting the instruction memory
package mipstest_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } probe_state_e;

    localparam logic PROBE_SEL_DATA = 1'b0;
    localparam logic PROBE_SEL_INST = 1'b1;

endpackage

// File: rtl/probe_timeout_ctr.sv
// Grant-wait timer for the probe responder. Built only when
// MEM_PROBE_TIMEOUT_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clr        : force the count to zero (held while not waiting for a grant)
//   en         : one more ungranted wait cycle is in progress
//   expired    : the current wait cycle is the TIMEOUT-th one in a row
module probe_timeout_ctr #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    // Count holds the number of ungranted cycles already completed, so the
    // wait cycle that sees TIMEOUT-1 is the last one allowed.
    assign expired = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_probe_responder.sv
// Memory probe responder: accepts one read probe at a time, fetches the word
// from the data or instruction memory through its arbiter, and returns it on
// a valid/ready response channel. Data-memory probes beyond the data address
// space are answered with an error and never reach the arbiter.
// Optional feature macro: MEM_PROBE_TIMEOUT_EN -- abandon a request after
// TIMEOUT ungranted cycles and answer with an error.
//   probe_valid/probe_ready/probe_sel/probe_addr : request channel
//   resp_valid/resp_ready/resp_data/resp_err     : response channel
//   dmem_req/dmem_gnt/dmem_addr/dmem_rdata       : data memory arbiter port
//   imem_req/imem_gnt/imem_addr/imem_rdata       : instruction memory arbiter port
//
// state | meaning
// IDLE  | ready for a probe
// REQ   | requesting the selected memory, waiting for grant
// CAPT  | read issued last cycle, capturing read data
// RESP  | response presented until consumed
module mem_probe_responder
    import mipstest_pkg::*;
#(
    parameter int unsigned DATA_AW = 8,
    parameter int unsigned INST_AW = 10,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               probe_valid,
    output logic               probe_ready,
    input  logic               probe_sel,
    input  logic [INST_AW-1:0] probe_addr,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_data,
    output logic               resp_err,
    output logic               dmem_req,
    input  logic               dmem_gnt,
    output logic [DATA_AW-1:0] dmem_addr,
    input  logic [31:0]        dmem_rdata,
    output logic               imem_req,
    input  logic               imem_gnt,
    output logic [INST_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata
);

    probe_state_e       state_q, state_d;
    logic               sel_q, sel_d;
    logic [INST_AW-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic               addr_out_of_range;
    logic               sel_gnt;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;

    // Data memory is narrower than the probe address; any high bit set is
    // outside the data space.
    assign addr_out_of_range = ((probe_addr >> DATA_AW) != '0);
    assign sel_gnt   = (sel_q == PROBE_SEL_INST) ? imem_gnt   : dmem_gnt;
    assign sel_rdata = (sel_q == PROBE_SEL_INST) ? imem_rdata : dmem_rdata;

`ifdef MEM_PROBE_TIMEOUT_EN
    logic to_clr, to_en, to_expired;

    assign to_clr = (state_q != REQ);
    assign to_en  = (state_q == REQ) && !sel_gnt;

    probe_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    assign timeout_hit = to_en && to_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (probe_valid) begin
                    sel_d  = probe_sel;
                    addr_d = probe_addr;
                    data_d = 32'd0;
                    if ((probe_sel == PROBE_SEL_DATA) && addr_out_of_range) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (sel_gnt) begin
                    state_d = CAPT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    data_d  = 32'd0;
                    state_d = RESP;
                end
            end
            CAPT: begin
                data_d  = sel_rdata;
                state_d = RESP;
            end
            RESP: begin
                // Clearing here keeps resp_data/resp_err at 0 while idle.
                if (resp_ready) begin
                    data_d  = 32'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= PROBE_SEL_DATA;
            addr_q  <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        probe_ready = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        resp_data   = data_q;
        resp_err    = err_q;
        dmem_req    = (state_q == REQ) && (sel_q == PROBE_SEL_DATA);
        imem_req    = (state_q == REQ) && (sel_q == PROBE_SEL_INST);
        dmem_addr   = dmem_req ? addr_q[DATA_AW-1:0] : '0;
        imem_addr   = imem_req ? addr_q : '0;
    end

endmodule
